// File: rtl/mem_responder.sv
// Single-port word memory with a post-reset clear sweep, registered read data and access-violation pulses.
// Optional MEM_PARITY_EN adds a per-word even-parity bit with fault injection and a read parity check.
module mem_responder #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              par_inject,
  output logic              busy,
  output logic              err,
  output logic              parity_err
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic              wr_en;
  logic              rd_en;
  logic              par_bad;

  assign in_range = 32'(addr) < DEPTH;
  assign wr_en    = (state == READY) && write && in_range;
  assign rd_en    = (state == READY) && read && !write && in_range;

  // The clear sweep owns the write port until the last word is zeroed.
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[sweep_cnt] <= '0;
    else if (wr_en)
      mem[addr] <= data_in;
  end

`ifdef MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (state == INIT)
      par_mem[sweep_cnt] <= 1'b0;
    else if (wr_en)
      par_mem[addr] <= (^data_in) ^ par_inject;
  end

  assign par_bad = (^mem[addr]) != par_mem[addr];
`else
  logic unused_par;
  assign unused_par = par_inject;
  assign par_bad    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      sweep_cnt  <= '0;
      busy       <= 1'b1;
      data_out   <= '0;
      err        <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      err        <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST) begin
            state     <= READY;
            busy      <= 1'b0;
            sweep_cnt <= '0;
          end
          if (read || write)
            err <= 1'b1;
        end
        READY: begin
          if (rd_en) begin
            data_out   <= mem[addr];
            parity_err <= par_bad;
          end
          // Simultaneous strobes still write; out-of-range strobes do nothing else.
          if ((read && write) || ((read || write) && !in_range))
            err <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, address width.
REQ-002 SHALL have parameter DATA_W, default 8, data word width.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W, number of words.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port read  input  1  read strobe, sampled on posedge.
REQ-007 SHALL have port write  input  1  write strobe, sampled on posedge.
REQ-008 SHALL have port addr  input  ADDR_W  word address.
REQ-009 SHALL have port data_in  input  DATA_W  write data, from initiator.
REQ-010 SHALL have port data_out  output  DATA_W  registered read data, to initiator.
REQ-011 SHALL have port par_inject  input  1  parity fault injection; ignored unless MEM_PARITY_EN.
REQ-012 SHALL have port busy  output  1  high while clear sweep runs.
REQ-013 SHALL have port err  output  1  one-cycle access-violation pulse.
REQ-014 SHALL have port parity_err  output  1  one-cycle read parity mismatch pulse.

Function
REQ-015 SHALL implement FSM states INIT and READY; INIT -> READY after clearing the last word; READY -> INIT only via rst.
REQ-016 In INIT, SHALL write 0 to word sweep_cnt each cycle, sweep_cnt 0..DEPTH-1; busy=1 for exactly DEPTH cycles after rst release.
REQ-017 In INIT, SHALL ignore read/write; any strobe sampled high SHALL pulse err next cycle; data_out holds.
REQ-018 In READY, write=1 and read=0 SHALL store data_in at addr on that posedge.
REQ-019 In READY, read=1 and write=0 SHALL load mem[addr] into data_out on that posedge (latency 1 edge; valid by following negedge).
REQ-020 read=1 and write=1 together SHALL perform the write only, hold data_out, and pulse err for one cycle.
REQ-021 Read of an address written on the previous posedge SHALL return the new data (no stale read).
REQ-022 With no strobe, data_out SHALL hold its last value.
REQ-023 addr SHALL use the low ADDR_W bits only; with DEPTH < 2**ADDR_W, out-of-range accesses SHALL be ignored and pulse err.

Reset
REQ-024 rst SHALL immediately force data_out=0, err=0, parity_err=0, busy=1, sweep_cnt=0, state=INIT.
REQ-025 rst asserted mid-sweep or mid-access SHALL restart the sweep from word 0; a partially applied write is discarded by the clear.

Configuration
REQ-026 Macro MEM_PARITY_EN defined: each word SHALL store an extra even-parity bit, inverted on write when par_inject=1; INIT stores correct parity for 0.
REQ-027 With MEM_PARITY_EN, a read whose stored parity mismatches the stored data SHALL pulse parity_err with data_out update; data is still returned.
REQ-028 Without MEM_PARITY_EN, no parity storage SHALL exist, par_inject SHALL be ignored, parity_err SHALL be constant 0.

Verification
REQ-029 Release rst, count busy cycles -> busy high exactly 32 cycles, then all 32 reads return 'h00.
REQ-030 Write addr=i data=i for i=0..31, read back each -> data_out==i, err never set.
REQ-031 Write during INIT (addr 3, 'hA5), read addr 3 after busy falls -> err pulsed once, data_out='h00.
REQ-032 Write addr 7 'h3C, then read=1 and write=1 together at addr 7 with data 'hFF -> err=1 one cycle, data_out unchanged, later read of addr 7 returns 'hFF.
REQ-033 Assert rst at sweep_cnt=10 after filling memory with 'h55 -> busy restarts, 32 busy cycles, all words read 'h00.
REQ-034 With MEM_PARITY_EN, write addr 4 'h81 with par_inject=1, read addr 4 -> data_out='h81, parity_err=1 one cycle; without macro parity_err stays 0.
